fifo_serial_tx: RTL
===================

Name: fifo_serial_tx

Overview:
- Drain-side companion to the team's 8-deep byte FIFO.
- Decides when the FIFO holds data and pops one byte at a time with ren.
- Serializes each byte onto a single-wire, UART-style line: start bit, 8 data bits LSB first, stop bit.
- The FIFO exposes no full/empty flags, so the block keeps a shadow occupancy count by observing the writer's wen.

Parameters:
- DATA_W, 8, byte width; must equal the FIFO width.
- DEPTH, 8, FIFO capacity; shadow counter saturates here.
- BIT_CYC, 4, clocks per serial bit (≥1).

Ports:
- clk, input, 1, clock; all state changes on posedge.
- rst_n, input, 1, synchronous, active-low reset; shared with the FIFO.
- fifo_wen_mon, input, 1, copy of the FIFO writer's wen.
- fifo_ren, output, 1, read strobe to FIFO ren.
- fifo_dout, input, DATA_W, FIFO read data.
- fifo_error, input, 1, FIFO error flag.
- tx, output, 1, serial line; idles high.
- busy, output, 1, high whenever FSM is not IDLE.
- occupancy, output, 4, shadow FIFO count, 0..DEPTH.
- err, output, 1, sticky error.

Behaviour:
- Reset (rst_n low at a posedge):
  - state=IDLE, occupancy=0, err=0, tx=1, busy=0, shift register=0, bit/cycle counters=0.
  - fifo_ren=0 while rst_n is low.
  - Reset mid-frame aborts the frame; tx=1 from the next cycle.
- FIFO contract:
  - ren has priority over wen; a write in the same cycle as a read is lost.
  - fifo_dout is valid only in the cycle after ren is sampled; at other times it is undefined.
- fifo_ren (combinational): asserted iff state==IDLE && occupancy!=0 && !fifo_wen_mon && rst_n. This rule guarantees ren and wen are never high in the same cycle.
- Occupancy update, per posedge:
  - ren → occupancy-1.
  - else wen_mon && occupancy<DEPTH → occupancy+1.
  - else wen_mon && occupancy==DEPTH → unchanged, set err (FIFO overflow).
- err: sticky. Set by the overflow above or by fifo_error sampled high. Cleared only by reset.
- FSM states: IDLE, LOAD, START, DATA, STOP.
  - IDLE: tx=1. If fifo_ren is high, go to LOAD.
  - LOAD, exactly 1 cycle: capture fifo_dout into shift register; go to START.
  - START: tx=0 for BIT_CYC cycles; go to DATA with bit index 0.
  - DATA: tx=shift[0] for BIT_CYC cycles per bit. Then shift right and increment bit index. After bit DATA_W-1, go to STOP.
  - STOP: tx=1 for BIT_CYC cycles; go to IDLE.
- Timing: tx is registered. If ren is high in cycle 0:
  - cycles 2..2+BIT_CYC-1: start bit.
  - data bit i in cycles 2+BIT_CYC*(1+i) onward.
  - stop bit ends at cycle 1+10*BIT_CYC.
  - IDLE at cycle 2+10*BIT_CYC; the earliest next ren is in that cycle.
  - Back-to-back period = 10*BIT_CYC+2 clocks (42 at defaults).
- busy=1 from cycle 1 through the last STOP cycle.
- Writes may continue during a frame; occupancy tracks them.
- A write in the IDLE cycle with occupancy>0 defers ren by one cycle.
- Counters: bit counter 3 bits and wraps naturally. Cycle counter width is clog2(BIT_CYC)+1 and resets at each bit boundary.

Decomposition:
- Shared package:
  - constants DATA_W, DEPTH, BIT_CYC defaults.
  - FSM state enum {IDLE, LOAD, START, DATA, STOP} with 3-bit encoding.
  - occupancy width constant = clog2(DEPTH+1).
- One natural sub-module, fifo_occ_track: shadow counter plus overflow detect (inputs wen_mon, ren; outputs occupancy, ovf). It is reusable by a future writer-side block.

Test Plan:
- Write 0xA5 once, then idle. Expected:
  - fifo_ren pulses 1 cycle, one cycle after the write.
  - tx shows 0 (4 clk), then 1,0,1,0,0,1,0,1 (4 clk each), then 1 (4 clk).
  - occupancy 1→0; err=0.
- Write 3 bytes back-to-back (0x01, 0x80, 0xFF). Expected:
  - occupancy peaks at 3.
  - three frames spaced 42 clocks apart, LSB-first data correct.
  - busy drops only after the third stop bit.
- Hold wen_mon high continuously with occupancy 1. Expected: fifo_ren stays 0 while wen_mon is high, asserts in the first cycle wen_mon is low, and is never high concurrently with wen_mon.
- Issue 9 writes with no reads possible (busy mid-frame). Expected: occupancy saturates at 8, err latches 1 on the 9th write and stays 1.
- Assert rst_n low for 1 cycle during DATA bit 3. Expected: next cycle tx=1, busy=0, occupancy=0, err=0, fifo_ren=0.
- Drive fifo_error=1 for 1 cycle while IDLE. Expected: err=1 from the next cycle until reset; serialization is unaffected.

Source files
------------

// File: rtl/fifo_serial_tx_pkg.sv
// Shared constants and FSM encoding for the FIFO drain-side serializer
// and its shadow occupancy tracker.
package fifo_serial_tx_pkg;

   localparam int DATA_W_DEF  = 8;
   localparam int DEPTH_DEF   = 8;
   localparam int BIT_CYC_DEF = 4;
   localparam int OCC_W_DEF   = $clog2(DEPTH_DEF + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_START = 3'd2,
      S_DATA  = 3'd3,
      S_STOP  = 3'd4
   } state_e;

endpackage

// File: rtl/fifo_serial_tx_if.sv
// Signal bundle between the FIFO environment and the serializer.
// The serializer sits on the slave side; the FIFO/writer side is the master.
interface fifo_serial_tx_if
   import fifo_serial_tx_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int OCC_W  = OCC_W_DEF
);

   logic              fifo_wen_mon;
   logic              fifo_ren;
   logic [DATA_W-1:0] fifo_dout;
   logic              fifo_error;
   logic              tx;
   logic              busy;
   logic [OCC_W-1:0]  occupancy;
   logic              err;

   modport master (
      output fifo_wen_mon, fifo_dout, fifo_error,
      input  fifo_ren, tx, busy, occupancy, err
   );

   modport slave (
      input  fifo_wen_mon, fifo_dout, fifo_error,
      output fifo_ren, tx, busy, occupancy, err
   );

endinterface

// File: rtl/fifo_serial_tx_occ_track.sv
// Shadow occupancy counter for a flagless FIFO, built from observed
// read/write strobes. Reads win over writes; a write into a full FIFO flags ovf.
module fifo_occ_track
   import fifo_serial_tx_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int OCC_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wen_mon_i,
   input  logic             ren_i,
   output logic [OCC_W-1:0] occupancy_o,
   output logic             ovf_o
);

   logic [OCC_W-1:0] occ_q, occ_d;
   logic             full;

   assign full  = (occ_q == OCC_W'(DEPTH));
   assign ovf_o = wen_mon_i && !ren_i && full;

   always_comb begin
      occ_d = occ_q;
      if (ren_i) begin
         if (occ_q != '0) occ_d = occ_q - OCC_W'(1);
      end else if (wen_mon_i && !full) begin
         occ_d = occ_q + OCC_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) occ_q <= '0;
      else        occ_q <= occ_d;
   end

   assign occupancy_o = occ_q;

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops bytes from a flagless FIFO and serializes them UART-style
// (start, DATA_W bits LSB first, stop) with BIT_CYC clocks per bit.
module fifo_serial_tx
   import fifo_serial_tx_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int DEPTH   = DEPTH_DEF,
   parameter int BIT_CYC = BIT_CYC_DEF
) (
   input logic             clk,
   input logic             rst_n,
   fifo_serial_tx_if.slave bus
);

   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam int CYC_W = $clog2(BIT_CYC) + 1;
   localparam int BIT_W = $clog2(DATA_W);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [CYC_W-1:0]  cyc_q, cyc_d;
   logic              tx_q, tx_d;
   logic              err_q, err_d;
   logic              ren;
   logic              ovf;
   logic              bit_end;
   logic [OCC_W-1:0]  occ;

   fifo_occ_track #(
      .DEPTH (DEPTH),
      .OCC_W (OCC_W)
   ) u_occ (
      .clk         (clk),
      .rst_n       (rst_n),
      .wen_mon_i   (bus.fifo_wen_mon),
      .ren_i       (ren),
      .occupancy_o (occ),
      .ovf_o       (ovf)
   );

   // Holding off while the writer is active keeps ren and wen mutually exclusive.
   assign ren     = (state_q == S_IDLE) && (occ != '0) && !bus.fifo_wen_mon && rst_n;
   assign bit_end = (cyc_q == CYC_W'(BIT_CYC - 1));

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      cyc_d   = cyc_q;
      err_d   = err_q | ovf | bus.fifo_error;

      case (state_q)
         S_IDLE: begin
            cyc_d = '0;
            bit_d = '0;
            if (ren) state_d = S_LOAD;
         end
         S_LOAD: begin
            shift_d = bus.fifo_dout;
            cyc_d   = '0;
            state_d = S_START;
         end
         S_START: begin
            if (bit_end) begin
               cyc_d   = '0;
               bit_d   = '0;
               state_d = S_DATA;
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cyc_d   = '0;
               shift_d = shift_q >> 1;
               bit_d   = bit_q + BIT_W'(1);
               if (bit_q == BIT_W'(DATA_W - 1)) state_d = S_STOP;
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end
         S_STOP: begin
            if (bit_end) begin
               cyc_d   = '0;
               state_d = S_IDLE;
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // tx is registered, so it is derived from the state being entered.
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         bit_q   <= '0;
         cyc_q   <= '0;
         tx_q    <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         cyc_q   <= cyc_d;
         tx_q    <= tx_d;
         err_q   <= err_d;
      end
   end

   assign bus.fifo_ren  = ren;
   assign bus.tx        = tx_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.occupancy = occ;
   assign bus.err       = err_q;

endmodule
